uart_rx_fifo: RTL
=================

Name: uart_rx_fifo

Overview:
UART receiver (8N1, LSB first) with an input synchronizer, mid-bit sampling, start-glitch rejection and framing-error detection. Received bytes are pushed into a small FIFO and drained by the consumer through a valid/ready handshake. It is the receive end paired with the team's UART_TX. It replaces the bare byte register when the consumer cannot take every byte the moment it arrives.

Parameters:
p_CLKs_PB, 217, clocks per bit (25 MHz / 115200); must be >= 4
p_FIFO_DEPTH, 4, FIFO entries; power of two, >= 2

Ports:
i_Clk  input  1  system clock
i_Rst  input  1  synchronous reset, active-high
i_Rx_UART  input  1  serial line, idle high, asynchronous to i_Clk
o_Rx_Byte  output  8  FIFO head byte; valid only while o_Rx_Valid=1
o_Rx_Valid  output  1  FIFO not empty
i_Rx_Ready  input  1  consumer accepts head when o_Rx_Valid=1
o_Rx_Count  output  $clog2(p_FIFO_DEPTH)+1  bytes held in FIFO
o_Rx_Busy  output  1  receiver state != IDLE
o_Frame_Err  output  1  1-cycle pulse: stop bit sampled 0
o_Overrun  output  1  1-cycle pulse: byte dropped because FIFO full

Behaviour:
- Reset: synchronizer FFs=1, state=IDLE, bit/clock counters=0, FIFO empty. Outputs: o_Rx_Byte=0, o_Rx_Valid=0, o_Rx_Count=0, o_Rx_Busy=0, o_Frame_Err=0, o_Overrun=0. Reset aborts any frame in progress and flushes the FIFO.
- Synchronizer: 2 FFs on i_Rx_UART, giving 2 cycles of latency. All logic uses the synced bit s_rx.
- Clock counter runs 0..p_CLKs_PB-1 inside each state.
- IDLE: when s_rx=0 -> START, counter=0.
- START: at counter=(p_CLKs_PB-1)/2 (integer division):
  - s_rx=0 -> DATA, counter=0, bit index=0.
  - s_rx=1 -> IDLE (glitch rejected, nothing pushed, no error).
- DATA: at counter=p_CLKs_PB-1, shift s_rx into bit [index] (LSB first).
  - After index 7 -> STOP (or PARITY when the optional feature is enabled).
- STOP: at counter=p_CLKs_PB-1, sample the stop bit.
  - s_rx=1 -> push request, then IDLE.
  - s_rx=0 -> o_Frame_Err pulse, byte discarded, -> WAIT_HIGH.
- WAIT_HIGH: stays until s_rx=1, then IDLE. A held break line produces exactly one error, not repeated frames.
- Push: the byte is written in the cycle after the stop-bit sample. o_Rx_Valid rises the following cycle when the FIFO was empty.
- Pop: occurs on a cycle where o_Rx_Valid & i_Rx_Ready. The next head appears the next cycle (registered read).
- Full FIFO, push with no pop: byte dropped, o_Overrun pulses, contents unchanged.
- Full FIFO, push and pop in the same cycle: both take effect, count unchanged, no overrun.
- Empty FIFO, push in a cycle with i_Rx_Ready=1: push only (valid was 0).
- Pointers wrap modulo p_FIFO_DEPTH. The count distinguishes full from empty.
- i_Rx_Ready while o_Rx_Valid=0 is ignored.
- o_Rx_Busy=1 in START/DATA/PARITY/STOP/WAIT_HIGH.

Optional Feature:
UART_RX_PARITY_EN
- Defined:
  - Frame is 8E1; PARITY state is inserted between DATA and STOP and samples at counter=p_CLKs_PB-1.
  - Adds output o_Parity_Err (1-cycle pulse) when received parity differs from the XOR of the data bits (even parity).
  - A parity-bad byte is discarded and not pushed; the stop bit is still checked.
- Undefined: 8N1, no PARITY state, no o_Parity_Err port.

Test Plan:
1. Reset, then send 0x05 at 8680 ns/bit (40 ns clock) -> o_Rx_Valid=1, o_Rx_Byte=0x05, o_Rx_Count=1, o_Frame_Err/o_Overrun never pulse.
2. i_Rx_Ready=0, send 0x11,0x22,0x33,0x44,0x55 -> count saturates at 4, one o_Overrun pulse on 0x55; then Ready=1 pops 0x11,0x22,0x33,0x44 in order, one per cycle.
3. Send 0xA5 with stop bit forced 0, line held low 3 bit periods -> exactly one o_Frame_Err pulse, nothing pushed, o_Rx_Busy stays 1 until the line returns high; next frame 0xFF received correctly.
4. 1000 ns low glitch on idle line -> START aborts to IDLE, o_Rx_Count=0, no error; subsequent 0x3C received.
5. Assert i_Rst mid-DATA of 0x81 with 2 bytes queued -> next cycle all outputs at reset values; a fresh 0x7E is received correctly after the line idles one frame.
6. With UART_RX_PARITY_EN: 0x07 with parity 1 -> accepted; 0x07 with parity 0 -> o_Parity_Err pulse, nothing pushed.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1, LSB first) feeding a small valid/ready FIFO.
// Define UART_RX_PARITY_EN for an 8E1 frame with an extra o_Parity_Err output.
module uart_rx_fifo #(
    parameter int p_CLKs_PB    = 217,
    parameter int p_FIFO_DEPTH = 4
) (
    input  logic                            i_Clk,
    input  logic                            i_Rst,
    input  logic                            i_Rx_UART,
    output logic [7:0]                      o_Rx_Byte,
    output logic                            o_Rx_Valid,
    input  logic                            i_Rx_Ready,
    output logic [$clog2(p_FIFO_DEPTH):0]   o_Rx_Count,
    output logic                            o_Rx_Busy,
    output logic                            o_Frame_Err,
`ifdef UART_RX_PARITY_EN
    output logic                            o_Parity_Err,
`endif
    output logic                            o_Overrun
);

    localparam int CW   = $clog2(p_CLKs_PB);
    localparam int AW   = $clog2(p_FIFO_DEPTH);
    localparam int CNTW = AW + 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(p_CLKs_PB - 1);
    localparam logic [CW-1:0]   CNT_MID  = CW'((p_CLKs_PB - 1) / 2);
    localparam logic [CNTW-1:0] FIFO_FULL = CNTW'(p_FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t          state, state_n;
    logic            rx_meta, s_rx;
    logic [CW-1:0]   clk_cnt, cnt_n;
    logic [2:0]      bit_idx, idx_n;
    logic [7:0]      shift_reg, shift_n;
    logic            push_req, push_n;
    logic            frame_err_n;
`ifdef UART_RX_PARITY_EN
    logic            parity_bad, parity_bad_n;
    logic            parity_err_n;
`endif

    logic [7:0]      mem [p_FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CNTW-1:0] count;
    logic            pop, do_push, overrun_n;

    // Two-flop synchronizer; idles high so reset never looks like a start bit.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            rx_meta <= 1'b1;
            s_rx    <= 1'b1;
        end else begin
            rx_meta <= i_Rx_UART;
            s_rx    <= rx_meta;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state       <= S_IDLE;
            clk_cnt     <= '0;
            bit_idx     <= '0;
            shift_reg   <= '0;
            push_req    <= 1'b0;
            o_Frame_Err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bad   <= 1'b0;
            o_Parity_Err <= 1'b0;
`endif
        end else begin
            state       <= state_n;
            clk_cnt     <= cnt_n;
            bit_idx     <= idx_n;
            shift_reg   <= shift_n;
            push_req    <= push_n;
            o_Frame_Err <= frame_err_n;
`ifdef UART_RX_PARITY_EN
            parity_bad   <= parity_bad_n;
            o_Parity_Err <= parity_err_n;
`endif
        end
    end

    always_comb begin
        state_n     = state;
        cnt_n       = clk_cnt + 1'b1;
        idx_n       = bit_idx;
        shift_n     = shift_reg;
        push_n      = 1'b0;
        frame_err_n = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_bad_n = parity_bad;
        parity_err_n = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                cnt_n = '0;
                if (!s_rx) state_n = S_START;
            end
            // Re-check the line half a bit in so short glitches are dropped.
            S_START: begin
                if (clk_cnt == CNT_MID) begin
                    cnt_n = '0;
                    idx_n = '0;
`ifdef UART_RX_PARITY_EN
                    parity_bad_n = 1'b0;
`endif
                    state_n = s_rx ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (clk_cnt == CNT_LAST) begin
                    cnt_n            = '0;
                    shift_n[bit_idx] = s_rx;
                    idx_n            = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_n = S_PARITY;
`else
                        state_n = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (clk_cnt == CNT_LAST) begin
                    cnt_n        = '0;
                    parity_bad_n = s_rx ^ (^shift_reg);
                    parity_err_n = s_rx ^ (^shift_reg);
                    state_n      = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (clk_cnt == CNT_LAST) begin
                    cnt_n = '0;
                    if (s_rx) begin
`ifdef UART_RX_PARITY_EN
                        push_n = !parity_bad;
`else
                        push_n = 1'b1;
`endif
                        state_n = S_IDLE;
                    end else begin
                        frame_err_n = 1'b1;
                        state_n     = S_WAIT_HIGH;
                    end
                end
            end
            // A held break reports once, then waits for the line to recover.
            S_WAIT_HIGH: begin
                cnt_n = '0;
                if (s_rx) state_n = S_IDLE;
            end
            default: begin
                cnt_n   = '0;
                state_n = S_IDLE;
            end
        endcase
    end

    assign o_Rx_Busy  = (state != S_IDLE);
    assign o_Rx_Valid = (count != '0);
    assign o_Rx_Count = count;
    assign o_Rx_Byte  = o_Rx_Valid ? mem[rd_ptr] : 8'h00;

    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign pop       = o_Rx_Valid & i_Rx_Ready;
    assign do_push   = push_req & ((count != FIFO_FULL) | pop);
    assign overrun_n = push_req & (count == FIFO_FULL) & ~pop;

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            o_Overrun <= 1'b0;
        end else begin
            o_Overrun <= overrun_n;
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge i_Clk) begin
        if (do_push) mem[wr_ptr] <= shift_reg;
    end

endmodule
